uart_tx_sched: RTL and testbench

Arbitrating serializer that shares the single UART transmit byte channel between the two message sources of the UART command block: memory-dump words (`rdata_snd_start`/`rdata_snd`) and CPU status words (`cpust_start`/`cpust_data`). Each granted request becomes an ASCII-hex message (8 uppercase hex digits, MSB first, plus a terminator) driven byte by byte over a valid/ready handshake. It returns `flushing_wq` to the command block when a message completes, which releases that block's send-wait states.

---
 rtl/uart_tx_sched.sv | 248 ++++++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Arbitrating ASCII-hex serializer: shares one UART byte channel between dump
// words and CPU status words, pulsing flushing_wq when a message completes.
module uart_tx_sched #(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdata_snd_start,
    input  logic [31:0] rdata_snd,
    input  logic        cpust_start,
    input  logic [31:0] cpust_data,
    input  logic        read_stop,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        flushing_wq,
    output logic        msg_src,
    output logic        sched_busy,
    output logic        overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEX  = 2'd1;
    localparam logic [1:0] ST_TERM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam logic [3:0] LINE_LAST = 4'(LINE_WORDS - 1);

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n <= 4'd9) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    logic [1:0]  state_q, state_d;
    logic        dump_pend_q, dump_pend_d;
    logic [31:0] dump_hold_q, dump_hold_d;
    logic        st_pend_q, st_pend_d;
    logic [31:0] st_hold_q, st_hold_d;
    logic        overrun_q, overrun_d;
    logic        rr_q, rr_d;
    logic [31:0] shift_q, shift_d;
    logic [2:0]  digit_q, digit_d;
    logic        crlf_q, crlf_d;
    logic        term_second_q, term_second_d;
    logic        abort_q, abort_d;
    logic [3:0]  line_q, line_d;
    logic        src_q, src_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        flush_q, flush_d;

    logic        accept;
    logic        dump_req;
    logic        grant_dump;
    logic        grant_st;
    logic        dump_active;
    logic        dump_stop;
    logic        use_crlf;
    logic [31:0] grant_word;

    always_comb begin
        state_d       = state_q;
        dump_pend_d   = dump_pend_q;
        dump_hold_d   = dump_hold_q;
        st_pend_d     = st_pend_q;
        st_hold_d     = st_hold_q;
        overrun_d     = overrun_q;
        rr_d          = rr_q;
        shift_d       = shift_q;
        digit_d       = digit_q;
        crlf_d        = crlf_q;
        term_second_d = term_second_q;
        abort_d       = abort_q;
        line_d        = line_q;
        src_d         = src_q;
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        flush_d       = 1'b0;
        grant_dump    = 1'b0;
        grant_st      = 1'b0;
        use_crlf      = 1'b0;

        accept      = tx_valid_q & tx_ready;
        dump_req    = dump_pend_q & ~read_stop;
        dump_active = ((state_q == ST_HEX) || (state_q == ST_TERM)) && !src_q;
        dump_stop   = read_stop | abort_q;

        // rr_q set means status wins the next contested arbitration
        if (state_q == ST_IDLE) begin
            if (dump_req && st_pend_q) begin
                grant_st   = rr_q;
                grant_dump = ~rr_q;
                rr_d       = ~rr_q;
            end else if (dump_req) begin
                grant_dump = 1'b1;
            end else if (st_pend_q) begin
                grant_st = 1'b1;
            end
        end
        grant_word = grant_st ? st_hold_q : dump_hold_q;

        if (dump_active && read_stop) begin
            abort_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_dump || grant_st) begin
                    state_d       = ST_HEX;
                    src_d         = grant_st;
                    shift_d       = grant_word;
                    digit_d       = 3'd0;
                    term_second_d = 1'b0;
                    abort_d       = 1'b0;
                    tx_valid_d    = 1'b1;
                    tx_data_d     = hex_char(grant_word[31:28]);
                    if (grant_st) begin
                        line_d = 4'd0;
                    end
                end
            end
            ST_HEX: begin
                if (accept) begin
                    if (!src_q && dump_stop) begin
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        abort_d    = 1'b0;
                    end else if (digit_q == 3'd7) begin
                        use_crlf      = src_q || (line_q == LINE_LAST);
                        state_d       = ST_TERM;
                        crlf_d        = use_crlf;
                        term_second_d = 1'b0;
                        tx_data_d     = use_crlf ? CH_CR : CH_SP;
                        if (!src_q) begin
                            line_d = use_crlf ? 4'd0 : line_q + 4'd1;
                        end
                    end else begin
                        shift_d   = {shift_q[27:0], 4'h0};
                        digit_d   = digit_q + 3'd1;
                        tx_data_d = hex_char(shift_q[27:24]);
                    end
                end
            end
            ST_TERM: begin
                if (accept) begin
                    if (!src_q && dump_stop) begin
                        state_d    = ST_IDLE;
                        tx_valid_d = 1'b0;
                        abort_d    = 1'b0;
                    end else if (crlf_q && !term_second_q) begin
                        term_second_d = 1'b1;
                        tx_data_d     = CH_LF;
                    end else begin
                        state_d    = ST_DONE;
                        tx_valid_d = 1'b0;
                        flush_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (read_stop) begin
            line_d = 4'd0;
        end

        // A start coinciding with its own grant is a fresh entry, not an overrun
        if (grant_dump) begin
            dump_pend_d = 1'b0;
        end
        if (read_stop) begin
            dump_pend_d = 1'b0;
        end else if (rdata_snd_start) begin
            if (dump_pend_q && !grant_dump) begin
                overrun_d = 1'b1;
            end
            dump_pend_d = 1'b1;
            dump_hold_d = rdata_snd;
        end

        if (grant_st) begin
            st_pend_d = 1'b0;
        end
        if (cpust_start) begin
            if (st_pend_q && !grant_st) begin
                overrun_d = 1'b1;
            end
            st_pend_d = 1'b1;
            st_hold_d = cpust_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            dump_pend_q   <= 1'b0;
            dump_hold_q   <= '0;
            st_pend_q     <= 1'b0;
            st_hold_q     <= '0;
            overrun_q     <= 1'b0;
            rr_q          <= 1'b0;
            shift_q       <= '0;
            digit_q       <= '0;
            crlf_q        <= 1'b0;
            term_second_q <= 1'b0;
            abort_q       <= 1'b0;
            line_q        <= '0;
            src_q         <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            flush_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            dump_pend_q   <= dump_pend_d;
            dump_hold_q   <= dump_hold_d;
            st_pend_q     <= st_pend_d;
            st_hold_q     <= st_hold_d;
            overrun_q     <= overrun_d;
            rr_q          <= rr_d;
            shift_q       <= shift_d;
            digit_q       <= digit_d;
            crlf_q        <= crlf_d;
            term_second_q <= term_second_d;
            abort_q       <= abort_d;
            line_q        <= line_d;
            src_q         <= src_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            flush_q       <= flush_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign flushing_wq = flush_q;
    assign msg_src     = src_q;
    assign sched_busy  = (state_q != ST_IDLE);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios plus random traffic, checked each
// cycle against a message-level model that holds every message as a byte queue.
module tb_uart_tx_sched;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdata_snd_start = 1'b0;
    logic [31:0] rdata_snd = '0;
    logic        cpust_start = 1'b0;
    logic [31:0] cpust_data = '0;
    logic        read_stop = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        flushing_wq;
    logic        msg_src;
    logic        sched_busy;
    logic        overrun;

    uart_tx_sched #(.LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .rdata_snd_start(rdata_snd_start), .rdata_snd(rdata_snd),
        .cpust_start(cpust_start), .cpust_data(cpust_data),
        .read_stop(read_stop),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .flushing_wq(flushing_wq), .msg_src(msg_src),
        .sched_busy(sched_busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: pending entries, message as byte queue, mode 0 idle / 1 sending / 2 done
    bit          m_pend [2];
    logic [31:0] m_hold [2];
    bit          m_ovr = 0;
    bit          m_pref_st = 0;
    int          m_line = 0;
    int          m_mode = 0;
    bit          m_src = 0;
    bit          m_abort = 0;
    logic [7:0]  m_q [$];

    function automatic logic [7:0] hexc(input int n);
        if (n < 10) return 8'(48 + n);
        return 8'(65 + n - 10);
    endfunction

    task automatic model_start(input bit src);
        logic [31:0] w;
        bit crlf;
        w = m_hold[src];
        m_q.delete();
        for (int i = 7; i >= 0; i--) m_q.push_back(hexc(int'((w >> (4 * i)) & 32'hF)));
        if (src) begin
            crlf = 1;
            m_line = 0;
        end else begin
            crlf = (m_line == LW - 1);
            m_line = crlf ? 0 : m_line + 1;
        end
        if (crlf) begin
            m_q.push_back(8'h0D);
            m_q.push_back(8'h0A);
        end else begin
            m_q.push_back(8'h20);
        end
        m_mode = 1;
        m_src = src;
        m_abort = 0;
    endtask

    task automatic model_step();
        bit dreq, gd, gs, old0, old1;
        if (rst) begin
            m_pend[0] = 0; m_pend[1] = 0; m_ovr = 0; m_pref_st = 0;
            m_line = 0; m_mode = 0; m_src = 0; m_abort = 0; m_q.delete();
            return;
        end
        gd = 0; gs = 0;
        dreq = m_pend[0] && !read_stop;
        old0 = m_pend[0];
        old1 = m_pend[1];
        case (m_mode)
            0: begin
                if (dreq && m_pend[1]) begin
                    if (m_pref_st) gs = 1; else gd = 1;
                    m_pref_st = gd;
                end else if (dreq) gd = 1;
                else if (m_pend[1]) gs = 1;
                if (gd || gs) model_start(gs);
            end
            1: begin
                if (tx_ready) begin
                    void'(m_q.pop_front());
                    if (!m_src && (read_stop || m_abort)) begin
                        m_mode = 0;
                        m_q.delete();
                    end else if (m_q.size() == 0) begin
                        m_mode = 2;
                    end
                end else if (!m_src && read_stop) begin
                    m_abort = 1;
                end
            end
            default: m_mode = 0;
        endcase
        if (gd) m_pend[0] = 0;
        if (read_stop) m_pend[0] = 0;
        else if (rdata_snd_start) begin
            if (old0 && !gd) m_ovr = 1;
            m_pend[0] = 1;
            m_hold[0] = rdata_snd;
        end
        if (gs) m_pend[1] = 0;
        if (cpust_start) begin
            if (old1 && !gs) m_ovr = 1;
            m_pend[1] = 1;
            m_hold[1] = cpust_data;
        end
        if (read_stop) m_line = 0;
    endtask

    bit         chk_en = 0;
    bit         s_valid = 0;
    logic [7:0] s_data = '0;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int         flush_cnt = 0;

    always @(posedge clk) begin
        if (s_valid && tx_ready) got_q.push_back(s_data);
        model_step();
        #1;
        s_valid = tx_valid;
        s_data  = tx_data;
        if (flushing_wq) flush_cnt++;
        if (chk_en) begin
            check_eq("tx_valid", tx_valid, m_mode == 1);
            check_eq("flushing_wq", flushing_wq, m_mode == 2);
            check_eq("sched_busy", sched_busy, m_mode != 0);
            check_eq("msg_src", msg_src, m_src);
            check_eq("overrun", overrun, m_ovr);
            if (m_mode == 1) check_eq("tx_data", tx_data, m_q[0]);
        end
    end

    bit bp_en = 0;
    int bp_cnt = 0;

    task automatic step();
        @(negedge clk);
        rdata_snd_start = 0;
        cpust_start = 0;
        read_stop = 0;
        if (bp_en) begin
            tx_ready = (bp_cnt % 3 == 0);
            bp_cnt++;
        end
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while (!(m_mode == 0 && !m_pend[0] && !m_pend[1]) && n < budget) begin
            step();
            n++;
        end
        check_eq("quiet_busy", sched_busy, 0);
    endtask

    task automatic clr();
        got_q.delete();
        exp_q.delete();
        flush_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        step();
        step();
        rst = 0;
    endtask

    task automatic add_msg(input logic [31:0] w, input bit crlf);
        for (int i = 7; i >= 0; i--) exp_q.push_back(hexc(int'((w >> (4 * i)) & 32'hF)));
        if (crlf) begin
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end else begin
            exp_q.push_back(8'h20);
        end
    endtask

    task automatic cmp_log(input string tag);
        check_eq({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq({tag, "_byte"}, got_q[i], exp_q[i]);
    endtask

    task automatic send_dump(input logic [31:0] w);
        rdata_snd_start = 1;
        rdata_snd = w;
        step();
    endtask

    task automatic send_st(input logic [31:0] w);
        cpust_start = 1;
        cpust_data = w;
        step();
    endtask

    initial begin
        logic [31:0] w [5];
        repeat (3) step();
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_flush", flushing_wq, 0);
        check_eq("rst_msg_src", msg_src, 0);
        check_eq("rst_busy", sched_busy, 0);
        check_eq("rst_overrun", overrun, 0);
        rst = 0;
        chk_en = 1;
        step();

        // single dump word
        clr();
        send_dump(32'h1234ABCD);
        wait_quiet(100);
        add_msg(32'h1234ABCD, 0);
        cmp_log("single");
        check_eq("single_flush", flush_cnt, 1);
        check_eq("single_src", msg_src, 0);

        // line wrap every LW dump words
        do_reset();
        clr();
        for (int k = 0; k < 5; k++) begin
            w[k] = $urandom;
            send_dump(w[k]);
            wait_quiet(100);
            add_msg(w[k], k == LW - 1);
        end
        cmp_log("wrap");
        check_eq("wrap_flush", flush_cnt, 5);

        // simultaneous requests, round robin
        do_reset();
        clr();
        rdata_snd_start = 1; rdata_snd = 32'hFFFFFFFF;
        cpust_start = 1; cpust_data = 32'h00000001;
        step();
        wait_quiet(100);
        rdata_snd_start = 1; rdata_snd = 32'h11111111;
        cpust_start = 1; cpust_data = 32'h22222222;
        step();
        wait_quiet(100);
        add_msg(32'hFFFFFFFF, 0);
        add_msg(32'h00000001, 1);
        add_msg(32'h22222222, 1);
        add_msg(32'h11111111, 0);
        cmp_log("arb");
        check_eq("arb_flush", flush_cnt, 4);

        // backpressure on a status message
        clr();
        bp_en = 1;
        bp_cnt = 0;
        w[0] = $urandom;
        send_st(w[0]);
        wait_quiet(200);
        bp_en = 0;
        tx_ready = 1;
        add_msg(w[0], 1);
        cmp_log("bp");
        check_eq("bp_flush", flush_cnt, 1);

        // abort a dump on its 3rd digit with a status request pending
        do_reset();
        clr();
        send_dump(32'hDEADBEEF);
        send_st(32'hCAFE0123);
        for (int n = 0; n < 50 && !(m_mode == 1 && m_q.size() == 7); n++) step();
        tx_ready = 0;
        read_stop = 1;
        step();
        tx_ready = 1;
        wait_quiet(100);
        exp_q.push_back(8'h44); exp_q.push_back(8'h45); exp_q.push_back(8'h41);
        add_msg(32'hCAFE0123, 1);
        cmp_log("abort");
        check_eq("abort_flush", flush_cnt, 1);
        clr();
        for (int k = 0; k < LW; k++) begin
            w[k] = $urandom;
            send_dump(w[k]);
            wait_quiet(100);
            add_msg(w[k], k == LW - 1);
        end
        cmp_log("after_abort");

        // overrun on status while a dump is active
        do_reset();
        clr();
        send_dump(32'h0BADF00D);
        send_st(32'hAAAA5555);
        send_st(32'h5555AAAA);
        wait_quiet(100);
        add_msg(32'h0BADF00D, 0);
        add_msg(32'h5555AAAA, 1);
        cmp_log("ovr");
        check_eq("ovr_sticky", overrun, 1);

        // reset mid-message
        send_dump(32'h87654321);
        repeat (4) step();
        rst = 1;
        step();
        check_eq("midrst_valid", tx_valid, 0);
        check_eq("midrst_data", tx_data, 8'h00);
        check_eq("midrst_busy", sched_busy, 0);
        check_eq("midrst_overrun", overrun, 0);
        check_eq("midrst_src", msg_src, 0);
        check_eq("midrst_flush", flushing_wq, 0);
        rst = 0;
        step();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            rdata_snd_start = ($urandom_range(0, 7) == 0);
            rdata_snd = $urandom;
            cpust_start = ($urandom_range(0, 9) == 0);
            cpust_data = $urandom;
            read_stop = ($urandom_range(0, 39) == 0);
            tx_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 599) == 0);
        end
        step();
        rst = 0;
        tx_ready = 1;
        wait_quiet(300);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
